// File: rtl/timekeeper_pkg.sv
// timekeeper_pkg: shared BCD limits, load validation and 24-to-12-hour mapping
package timekeeper_pkg;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_12 = 8'h12;
  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
    return v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v <= max;
  endfunction
  function automatic logic [7:0] hour12(input logic [7:0] h);
    logic [4:0] b;
    b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]) - 5'd12;
    return h == 8'h00 ? BCD_12 : h <= BCD_12 ? h : b >= 5'd10 ? {4'd1, 4'(b - 5'd10)} : {4'd0, b[3:0]};
  endfunction
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: packed-BCD counter 00..MAX_BCD; ports clk, reset (async), inc, ld/ld_val (load wins), q, wrap (inc at MAX_BCD)
module bcd_mod_counter
  import timekeeper_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = BCD_59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       ld,
  input  logic [7:0] ld_val,
  output logic [7:0] q,
  output logic       wrap
);
  logic [7:0] q_d, q_q;
  assign wrap = inc && q_q == MAX_BCD;
  assign q = q_q;
  always_comb
    q_d = ld ? ld_val : !inc ? q_q : wrap ? 8'h00 :
          q_q[3:0] == 4'd9 ? {q_q[7:4] + 4'd1, 4'd0} : q_q + 8'd1;
  always_ff @(posedge clk or posedge reset)
    if (reset) q_q <= '0;
    else q_q <= q_d;
endmodule

// File: rtl/timekeeper.sv
// timekeeper: BCD time-of-day clock; in clk, reset, en, mode24, load, load_h/m/s; out hour/minute/second, pm, tick, sbit/mbit/hbit, load_err
module timekeeper
  import timekeeper_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned PRESC_W  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       mode24,
  input  logic       load,
  input  logic [7:0] load_h,
  input  logic [7:0] load_m,
  input  logic [7:0] load_s,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic       pm,
  output logic       tick,
  output logic       sbit,
  output logic       mbit,
  output logic       hbit,
  output logic       load_err
);
  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);
  logic [PRESC_W-1:0] presc_d, presc_q;
  logic [3:0] pulse_d, pulse_q;
  logic [7:0] h24;
  logic load_ok, wrap_now, tick_now, s_wrap, m_wrap, h_wrap;
  assign load_ok = load && bcd_valid(load_h, BCD_23) && bcd_valid(load_m, BCD_59) && bcd_valid(load_s, BCD_59);
  assign wrap_now = en && presc_q == LAST;
  // a valid load overrides the tick; reset masks the combinational pulse
  assign tick_now = wrap_now && !load_ok;
  assign tick = tick_now && !reset;
  always_comb begin
    presc_d = load_ok || wrap_now ? '0 : en ? presc_q + PRESC_W'(1) : presc_q;
    pulse_d = {s_wrap, m_wrap, h_wrap, load && !load_ok};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      presc_q <= '0;
      pulse_q <= '0;
    end else begin
      presc_q <= presc_d;
      pulse_q <= pulse_d;
    end
  assign {sbit, mbit, hbit, load_err} = pulse_q;
  bcd_mod_counter #(.MAX_BCD(BCD_59)) u_sec (
    .clk(clk), .reset(reset), .inc(tick_now), .ld(load_ok), .ld_val(load_s), .q(second), .wrap(s_wrap)
  );
  bcd_mod_counter #(.MAX_BCD(BCD_59)) u_min (
    .clk(clk), .reset(reset), .inc(s_wrap), .ld(load_ok), .ld_val(load_m), .q(minute), .wrap(m_wrap)
  );
  bcd_mod_counter #(.MAX_BCD(BCD_23)) u_hour (
    .clk(clk), .reset(reset), .inc(m_wrap), .ld(load_ok), .ld_val(load_h), .q(h24), .wrap(h_wrap)
  );
  assign hour = mode24 ? h24 : hour12(h24);
  assign pm = !mode24 && h24 >= BCD_12;
endmodule

// File: tb/tb_timekeeper.sv
// tb_timekeeper: scoreboard bench for timekeeper against a seconds-of-day reference model
module tb_timekeeper;
  localparam int TD = 4;
  logic clk = 0, reset = 1, en = 0, mode24 = 1, load = 0;
  logic [7:0] load_h = 0, load_m = 0, load_s = 0;
  logic [7:0] hour, minute, second;
  logic pm, tick, sbit, mbit, hbit, load_err;
  typedef struct packed {
    logic [7:0] h, m, s;
    logic pm, tick, sb, mb, hb, err;
  } obs_t;
  obs_t exp_q[$];
  int checks = 0, passed = 0, cyc = 0;
  int t = 0, cnt = 0;
  bit sb_r = 0, mb_r = 0, hb_r = 0, err_r = 0;

  timekeeper #(.TICK_DIV(TD), .PRESC_W(3)) dut (
    .clk(clk), .reset(reset), .en(en), .mode24(mode24), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .hour(hour), .minute(minute), .second(second), .pm(pm), .tick(tick),
    .sbit(sbit), .mbit(mbit), .hbit(hbit), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction
  function automatic int dec(input logic [7:0] v);
    return int'(v >> 4) * 10 + int'(v & 8'h0f);
  endfunction
  function automatic bit ok(input logic [7:0] v, input int mx);
    return int'(v & 8'h0f) <= 9 && int'(v >> 4) <= 9 && dec(v) <= mx;
  endfunction

  // one clock cycle of stimulus: drive inputs, push the expected view, advance the model
  task automatic step(input bit r, input bit e, input bit m24, input bit ld,
                      input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls);
    obs_t x;
    bit valid, tk;
    int hh;
    @(posedge clk);
    #1;
    reset = r; en = e; mode24 = m24; load = ld; load_h = lh; load_m = lm; load_s = ls;
    if (r) begin
      t = 0; cnt = 0; sb_r = 0; mb_r = 0; hb_r = 0; err_r = 0;
    end
    valid = ld && ok(lh, 23) && ok(lm, 59) && ok(ls, 59);
    tk = !r && e && cnt == TD - 1 && !valid;
    hh = t / 3600;
    x.s = bcd(t % 60);
    x.m = bcd((t / 60) % 60);
    x.h = m24 ? bcd(hh) : bcd(hh % 12 == 0 ? 12 : hh % 12);
    x.pm = !m24 && hh >= 12;
    x.tick = tk;
    x.sb = sb_r; x.mb = mb_r; x.hb = hb_r; x.err = err_r;
    exp_q.push_back(x);
    if (!r) begin
      sb_r = 0; mb_r = 0; hb_r = 0;
      err_r = ld && !valid;
      if (valid) begin
        t = dec(lh) * 3600 + dec(lm) * 60 + dec(ls);
        cnt = 0;
      end else if (tk) begin
        cnt = 0;
        t = (t + 1) % 86400;
        sb_r = t % 60 == 0;
        mb_r = t % 3600 == 0;
        hb_r = t == 0;
      end else if (e) cnt++;
    end
  endtask

  task automatic run(input int n, input bit m24);
    for (int i = 0; i < n; i++) step(0, 1, m24, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = '{hour, minute, second, pm, tick, sbit, mbit, hbit, load_err};
      checks++;
      if (a === e) passed++;
      else $display("FAIL cycle%0d: got h=%h m=%h s=%h pm=%b tick=%b sbit=%b mbit=%b hbit=%b err=%b, expected h=%h m=%h s=%h pm=%b tick=%b sbit=%b mbit=%b hbit=%b err=%b",
                    cyc, a.h, a.m, a.s, a.pm, a.tick, a.sb, a.mb, a.hb, a.err,
                    e.h, e.m, e.s, e.pm, e.tick, e.sb, e.mb, e.hb, e.err);
    end
  end

  initial begin
    int k, pick;
    bit r, ld;
    logic [7:0] lh, lm, ls;
    // reset view in both display modes
    step(1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 8'h12, 8'h34, 8'h56);
    // first tick on the 4th enabled cycle after release
    run(6, 1);
    // 23:59:58 rolls through midnight
    step(0, 1, 1, 1, 8'h23, 8'h59, 8'h58);
    run(9, 1);
    // 12-hour display
    step(0, 1, 0, 1, 8'h00, 8'h30, 8'h00);
    run(2, 0);
    step(0, 1, 0, 1, 8'h13, 8'h05, 8'h00);
    run(2, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    // rejected loads, one coincident with a tick
    step(0, 1, 1, 1, 8'h10, 8'h20, 8'h60);
    run(2, 1);
    step(0, 1, 1, 1, 8'h24, 8'h00, 8'h00);
    run(1, 1);
    while (cnt != TD - 1) step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 8'h05, 8'h1A, 8'h00);
    run(3, 1);
    // hold mid-count
    run(2, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 0, 0);
    run(6, 1);
    // load coincident with a tick, and with seconds at 59
    while (cnt != TD - 1) step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 8'h07, 8'h59, 8'h59);
    run(TD + 1, 1);
    // reset mid-count, then against a load
    run(2, 1);
    step(1, 1, 1, 0, 0, 0, 0);
    run(5, 1);
    step(1, 1, 0, 1, 8'h01, 8'h02, 8'h03);
    run(5, 0);
    // randomized traffic biased toward carries
    for (int i = 0; i < 2000; i++) begin
      k = $urandom_range(0, 199);
      r = k == 0;
      ld = k >= 1 && k <= 10;
      pick = $urandom_range(0, 3);
      lh = 8'($urandom_range(0, 255));
      lm = 8'($urandom_range(0, 255));
      ls = 8'($urandom_range(0, 255));
      if (pick == 1) begin
        lh = 8'h23; lm = 8'h59; ls = bcd($urandom_range(50, 59));
      end else if (pick == 2) begin
        lh = bcd($urandom_range(0, 23)); lm = 8'h59; ls = bcd($urandom_range(55, 59));
      end else if (pick == 3) begin
        lh = bcd($urandom_range(0, 23)); lm = bcd($urandom_range(0, 59)); ls = bcd($urandom_range(0, 59));
      end
      step(r, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), ld, lh, lm, ls);
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/timekeeper.md
TIMEKEEPER -- requirements
Module: timekeeper

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per one-second tick; legal range 1 to 2^32-1.
REQ-002 Parameter PRESC_W, default 32, prescaler width; SHALL satisfy 2^PRESC_W > TICK_DIV-1.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  run enable; 0 freezes prescaler and time registers.
REQ-006 mode24  input  1  display mode; 1 = 24-hour, 0 = 12-hour.
REQ-007 load  input  1  single-cycle time-set strobe.
REQ-008 load_h, load_m, load_s  input  8 each  packed-BCD set value, always in 24-hour form.
REQ-009 hour, minute, second  output  8 each  packed-BCD time, tens digit in [7:4], units in [3:0].
REQ-010 pm  output  1  12-hour indicator; 1 when internal hour >= 12; 0 in 24-hour mode.
REQ-011 tick  output  1  one-cycle pulse per elapsed second.
REQ-012 sbit, mbit, hbit  output  1 each  one-cycle carry pulses: second 59->00, minute 59->00, hour 23->00.
REQ-013 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 while en=1 and wrap to 0; tick is asserted the cycle the prescaler equals TICK_DIV-1 with en=1.
REQ-015 On tick, second SHALL increment in BCD: x9 -> (x+1)0, 59 -> 00.
REQ-016 Minute SHALL increment only on the tick where second wraps; same BCD and 59 -> 00 rules.
REQ-017 Internal hour SHALL run 00..23 in BCD and increment only on the tick where both second and minute wrap; 23 -> 00.
REQ-018 sbit, mbit and hbit SHALL be registered and asserted in the same cycle the wrapped field first shows 00.
REQ-019 At 23:59:59 plus one tick, all three fields SHALL become 00 in one cycle, with sbit, mbit and hbit all asserted.
REQ-020 Load is valid only if every BCD digit is <= 9, load_s <= 59, load_m <= 59 and load_h <= 23.
REQ-021 A valid load SHALL write all three fields and clear the prescaler on the next edge, independent of en.
REQ-022 A valid load SHALL suppress tick, sbit, mbit and hbit in that cycle.
REQ-023 Load SHALL take priority over a coincident tick.
REQ-024 An invalid load SHALL leave all time state unchanged, let a coincident tick proceed normally, and pulse load_err one cycle later.
REQ-025 mode24=1: hour equals the internal hour.
REQ-026 mode24=0, display mapping: internal 00 -> 12; 01..12 -> unchanged; 13..23 -> minus 12.
REQ-027 mode24=0: pm = (internal hour >= 12).
REQ-028 Mode mapping SHALL be combinational from registered state, so mode24 changes take effect in the same cycle without disturbing timekeeping.
REQ-029 en=0 SHALL hold the prescaler and all fields; on en returning to 1, counting resumes from the held prescaler value.
REQ-030 TICK_DIV=1 SHALL tick every enabled cycle.

Reset
REQ-031 reset=1 SHALL force, asynchronously, prescaler=0 and internal time 00:00:00.
REQ-032 reset=1 SHALL force tick, sbit, mbit, hbit and load_err to 0.
REQ-033 During reset: hour=00 and pm=0 in 24-hour mode; hour=12 and pm=0 in 12-hour mode.
REQ-034 Reset asserted mid-count or coincident with load SHALL win; the first tick after release comes TICK_DIV enabled cycles later.

Structure
REQ-035 Shared package timekeeper_pkg SHALL hold constants BCD_59=8'h59, BCD_23=8'h23, BCD_12=8'h12.
REQ-036 timekeeper_pkg SHALL hold a BCD-validity function.
REQ-037 timekeeper_pkg SHALL hold a 24-to-12-hour mapping function.
REQ-038 One sub-module, bcd_mod_counter, SHALL be used.
REQ-039 bcd_mod_counter parameter MAX_BCD; ports inc, ld, ld_val, q, wrap.
REQ-040 bcd_mod_counter SHALL be instantiated three times: MAX_BCD 59, 59 and 23.
REQ-041 Carry chaining between the three instances SHALL be done in timekeeper.

Verification (bench TICK_DIV=4)
REQ-042 Reset release with en=1 -> first tick on the 4th cycle; second=01 after it.
REQ-043 Load 23:59:58, then 8 enabled cycles -> 23:59:59 then 00:00:00; sbit, mbit and hbit all pulse together once.
REQ-044 mode24=0, load 00:30:00 -> hour=12, pm=0; load 13:05:00 -> hour=01, pm=1; toggle mode24=1 -> hour=13, same cycle.
REQ-045 Load 8'h60 seconds or 8'h24 hours or digit 8'h1A -> load_err pulses once; time unchanged and ticking continues.
REQ-046 en=0 for 10 cycles mid-count -> no tick, fields held; resumes with remaining prescaler count.
REQ-047 Load coincident with tick -> loaded value appears; no increment or carry pulse that cycle; next tick TICK_DIV cycles later.
